// File: rtl/red_seq_pkg.sv
// Shared types and helpers for the RED byte-reduction sequencer.
// State encodings, accumulator width, sign extension and a 4-bit CLA slice.
package red_seq_pkg;

    localparam int RED_SUM_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUM_A = 3'd1,
        SUM_B = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [RED_SUM_W-1:0] sext_b10(input logic [7:0] x);
        return {{(RED_SUM_W-8){x[7]}}, x};
    endfunction

    function automatic logic [15:0] sext_10_16(input logic [RED_SUM_W-1:0] x);
        return {{(16-RED_SUM_W){x[RED_SUM_W-1]}}, x};
    endfunction

    // Returns {carry_out, sum[3:0]} with all carries in lookahead form.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

endpackage

// File: rtl/red_seq_if.sv
// Operand/result handshake bundle for red_seq.
interface red_seq_if #(parameter int DATA_W = 16);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              busy;

    modport master (
        output in_valid, a, b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/red_add10.sv
// 10-bit two's-complement adder from three CLA slices; carry-in 0, carry-out dropped.
module red_add10
    import red_seq_pkg::*;
(
    input  logic [RED_SUM_W-1:0] x,
    input  logic [RED_SUM_W-1:0] y,
    output logic [RED_SUM_W-1:0] sum
);
    logic [4:0] s0;
    logic [4:0] s1;

    assign s0       = cla4(x[3:0], y[3:0], 1'b0);
    assign s1       = cla4(x[7:4], y[7:4], s0[4]);
    assign sum[3:0] = s0[3:0];
    assign sum[7:4] = s1[3:0];
    // Top slice only carries two live bits; its carry-out is discarded.
    assign sum[9:8] = 2'(cla4({2'b00, x[9:8]}, {2'b00, y[9:8]}, s1[4]));
endmodule

// File: rtl/red_seq.sv
// Three-cycle RED sequencer: one shared 10-bit adder, valid/ready in and out, flush.
module red_seq
    import red_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SUM_W  = RED_SUM_W
) (
    input  logic      clk,
    input  logic      rst_n,
    red_seq_if.slave  bus
);
    state_t            state;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [SUM_W-1:0]  acc_a;
    logic [SUM_W-1:0]  acc_b;
    logic [DATA_W-1:0] result_q;
    logic              out_valid_q;
    logic [SUM_W-1:0]  add_x;
    logic [SUM_W-1:0]  add_y;
    logic [SUM_W-1:0]  add_s;

    // Operand mux in front of the single shared adder.
    always_comb begin
        add_x = '0;
        add_y = '0;
        case (state)
            SUM_A: begin
                add_x = sext_b10(op_a[7:0]);
                add_y = sext_b10(op_a[15:8]);
            end
            SUM_B: begin
                add_x = sext_b10(op_b[7:0]);
                add_y = sext_b10(op_b[15:8]);
            end
            FINAL: begin
                add_x = acc_a;
                add_y = acc_b;
            end
            default: ;
        endcase
    end

    red_add10 u_add (.x(add_x), .y(add_y), .sum(add_s));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            acc_a       <= '0;
            acc_b       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_a  <= bus.a;
                    op_b  <= bus.b;
                    state <= SUM_A;
                end
                SUM_A: begin
                    acc_a <= add_s;
                    state <= SUM_B;
                end
                SUM_B: begin
                    acc_b <= add_s;
                    state <= FINAL;
                end
                FINAL: begin
                    result_q    <= sext_10_16(add_s);
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_red_seq.sv
// Directed bench for red_seq: latency, arithmetic extremes, backpressure, flush, reset.
module tb_red_seq;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total;

    red_seq_if bus ();

    red_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair for exactly one edge while IDLE.
    task automatic accept(input logic [15:0] av, input logic [15:0] bv);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
        total++; if (bus.result !== 16'h0000) $display("FAIL reset_result got=%h exp=0000", bus.result); else pass_cnt++;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        accept(16'h0102, 16'h0304);
        total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL basic_busy got busy=%b rdy=%b exp 1/0", bus.busy, bus.in_ready); else pass_cnt++;
        tick(); tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
        tick();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
        total++; if (bus.result !== 16'h000A) $display("FAIL basic_result got=%h exp=000a", bus.result); else pass_cnt++;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL basic_release got vld=%b rdy=%b exp 0/1", bus.out_valid, bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_extremes();
        bus.out_ready = 1'b1;
        accept(16'h7F7F, 16'h7F7F);
        repeat (3) tick();
        total++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h01FC) $display("FAIL pos_extreme got vld=%b res=%h exp 1/01fc", bus.out_valid, bus.result); else pass_cnt++;
        tick();
        accept(16'h8080, 16'h8080);
        repeat (3) tick();
        total++; if (bus.out_valid !== 1'b1 || bus.result !== 16'hFE00) $display("FAIL neg_extreme got vld=%b res=%h exp 1/fe00", bus.out_valid, bus.result); else pass_cnt++;
        tick();
    endtask

    task automatic test_mixed();
        bus.out_ready = 1'b1;
        accept(16'hFF01, 16'h807F);
        // Now in SUM_A: new operands must be ignored.
        bus.in_valid = 1'b1;
        bus.a        = 16'h1234;
        bus.b        = 16'h5678;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL mixed_in_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        total++; if (bus.out_valid !== 1'b1 || bus.result !== 16'hFFFF) $display("FAIL mixed_result got vld=%b res=%h exp 1/ffff", bus.out_valid, bus.result); else pass_cnt++;
        tick();
        total++; if (bus.in_ready !== 1'b1) $display("FAIL mixed_idle got=%b exp=1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        accept(16'h0505, 16'h0000);
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.result !== 16'h000A || bus.busy !== 1'b1)
                $display("FAIL hold_%0d got vld=%b res=%h busy=%b exp 1/000a/1", i, bus.out_valid, bus.result, bus.busy);
            else pass_cnt++;
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", bus.out_valid, bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        accept(16'h1010, 16'h1010);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL flush_idle got busy=%b rdy=%b exp 0/1", bus.busy, bus.in_ready); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_novalid_%0d got=%b exp=0", i, bus.out_valid); else pass_cnt++;
            tick();
        end
        bus.flush = 1'b1;
        accept(16'h0101, 16'h0101);
        bus.flush = 1'b0;
        total++; if (bus.busy !== 1'b0) $display("FAIL flush_blocks_accept got busy=%b exp=0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        accept(16'h0303, 16'h0000);
        tick(); tick();
        rst_n     = 1'b0;
        bus.flush = 1'b1;
        tick();
        rst_n     = 1'b1;
        bus.flush = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL rst_mid_state got busy=%b vld=%b exp 0/0", bus.busy, bus.out_valid); else pass_cnt++;
        total++; if (bus.result !== 16'h0000) $display("FAIL rst_mid_result got=%h exp=0000", bus.result); else pass_cnt++;
        accept(16'h0101, 16'h0101);
        repeat (3) tick();
        total++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h0004) $display("FAIL post_rst_op got vld=%b res=%h exp 1/0004", bus.out_valid, bus.result); else pass_cnt++;
        tick();
    endtask

    initial begin
        pass_cnt = 0;
        total    = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_mixed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
